// File: rtl/prime_pkg.sv
// Shared state encoding and helpers for the prime search controller.
package prime_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLoad   = 3'd1,
      StTestSq = 3'd2,
      StDiv    = 3'd3,
      StCheck  = 3'd4,
      StEmit   = 3'd5,
      StNext   = 3'd6,
      StDone   = 3'd7
   } prime_state_t;

   localparam int unsigned FIRST_CAND = 2;

   // Operands are zero-extended to 64 bits so the square never truncates (WIDTH <= 64).
   function automatic logic sq_exceeds(input logic [63:0] div_v, input logic [63:0] cand_v);
      logic [127:0] sq;
      sq = {64'd0, div_v} * {64'd0, div_v};
      return sq > {64'd0, cand_v};
   endfunction

endpackage

// File: rtl/prime_rem_unit.sv
// Restoring remainder unit: one quotient bit per cycle, rem_done pulses WIDTH cycles after launch.
module prime_rem_unit
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             launch,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem,
   output logic             rem_done
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d, shift_q, shift_d, dsor_q, dsor_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] step_rem, step_shift, step_dsor;
   logic [WIDTH:0]   trial;

   always_comb begin
      // The first bit is resolved on the launch edge itself, giving exactly WIDTH cycles of latency.
      step_rem   = launch ? '0 : rem_q;
      step_shift = launch ? dividend : shift_q;
      step_dsor  = launch ? divisor : dsor_q;
      trial      = {step_rem, step_shift[WIDTH-1]};
      rem_d      = rem_q;
      shift_d    = shift_q;
      dsor_d     = dsor_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      if (launch || (cnt_q != '0)) begin
         if (trial >= {1'b0, step_dsor}) begin
            rem_d = WIDTH'(trial - {1'b0, step_dsor});
         end else begin
            rem_d = trial[WIDTH-1:0];
         end
         shift_d = step_shift << 1;
         dsor_d  = step_dsor;
         cnt_d   = launch ? CntW'(WIDTH - 1) : cnt_q - CntW'(1);
         done_d  = (cnt_d == '0);
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         rem_q   <= '0;
         shift_q <= '0;
         dsor_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         rem_q   <= rem_d;
         shift_q <= shift_d;
         dsor_q  <= dsor_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign rem      = rem_q;
   assign rem_done = done_q;

endmodule

// File: rtl/prime_search_ctrl.sv
// Trial-division prime search sequencer with a valid/ready prime stream.
// Define PRIME_SKIP_EVEN_EN to test only 2 and odd candidates with odd divisors.
module prime_search_ctrl
   import prime_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned COUNT_LIMIT = 1000000
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Abort,
   output logic             Prime_Valid,
   input  logic             Prime_Ready,
   output logic [WIDTH-1:0] Prime_Data,
   output logic [WIDTH-1:0] Prime_Count,
   output logic             Busy,
   output logic             Done
);

   localparam logic [WIDTH:0] LastCand = (WIDTH + 1)'(COUNT_LIMIT - 1);
   localparam bit             Trivial  = (COUNT_LIMIT <= FIRST_CAND);

   prime_state_t     state_q, state_d;
   logic [WIDTH-1:0] cand_q, cand_d, div_q, div_d, data_q, data_d, count_q, count_d;
   logic             valid_q, valid_d, done_q, done_d, busy_q, busy_d;
   logic             launch, rem_done;
   logic [WIDTH-1:0] rem, load_div, div_step;
   logic [WIDTH:0]   cand_nxt;

`ifdef PRIME_SKIP_EVEN_EN
   assign load_div = (cand_q > WIDTH'(FIRST_CAND)) ? WIDTH'(3) : WIDTH'(FIRST_CAND);
   assign div_step = WIDTH'(2);
   assign cand_nxt = {1'b0, cand_q} + ((cand_q == WIDTH'(FIRST_CAND)) ? (WIDTH + 1)'(1)
                                                                       : (WIDTH + 1)'(2));
`else
   assign load_div = WIDTH'(FIRST_CAND);
   assign div_step = WIDTH'(1);
   assign cand_nxt = {1'b0, cand_q} + (WIDTH + 1)'(1);
`endif

   prime_rem_unit #(
      .WIDTH(WIDTH)
   ) u_rem (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .launch  (launch),
      .dividend(cand_q),
      .divisor (div_q),
      .rem     (rem),
      .rem_done(rem_done)
   );

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      div_d   = div_q;
      data_d  = data_q;
      count_d = count_q;
      valid_d = valid_q;
      done_d  = done_q;
      launch  = 1'b0;
      if (Abort) begin
         state_d = StIdle;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (Start) begin
                  cand_d  = WIDTH'(FIRST_CAND);
                  count_d = '0;
                  done_d  = Trivial;
                  state_d = Trivial ? StDone : StLoad;
               end
            end
            StLoad: begin
               div_d   = load_div;
               state_d = StTestSq;
            end
            StTestSq: begin
               if (sq_exceeds(64'(div_q), 64'(cand_q))) begin
                  valid_d = 1'b1;
                  data_d  = cand_q;
                  state_d = StEmit;
               end else begin
                  launch  = 1'b1;
                  state_d = StDiv;
               end
            end
            StDiv: begin
               if (rem_done) state_d = StCheck;
            end
            StCheck: begin
               if (rem == '0) begin
                  state_d = StNext;
               end else begin
                  div_d   = div_q + div_step;
                  state_d = StTestSq;
               end
            end
            StEmit: begin
               if (Prime_Ready) begin
                  valid_d = 1'b0;
                  if (count_q != '1) count_d = count_q + WIDTH'(1);
                  state_d = StNext;
               end
            end
            StNext: begin
               // Compared one bit wider so the last step never wraps past the limit.
               if (cand_nxt > LastCand) begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  cand_d  = cand_nxt[WIDTH-1:0];
                  state_d = StLoad;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      busy_d = !((state_d == StIdle) || (state_d == StDone));
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
         cand_q  <= '0;
         div_q   <= '0;
         data_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         div_q   <= div_d;
         data_q  <= data_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign Prime_Valid = valid_q;
   assign Prime_Data  = data_q;
   assign Prime_Count = count_q;
   assign Busy        = busy_q;
   assign Done        = done_q;

endmodule

// File: tb/tb_prime_search_ctrl.sv
// Directed bench for prime_search_ctrl: four instances with different search limits.
module tb_prime_search_ctrl;

   localparam int W = 16;
`ifdef PRIME_SKIP_EVEN_EN
   localparam int AbortDelay = 10;
`else
   localparam int AbortDelay = 30;
`endif

   logic Clock = 1'b0;
   logic Reset_n = 1'b0;
   logic Start = 1'b0;
   logic Abort = 1'b0;
   logic Ready = 1'b1;

   logic         v20, b20, dn20, v3, b3, dn3, v2, b2, dn2, v50, b50, dn50;
   logic [W-1:0] d20, c20, d3, c3, d2, c2, d50, c50;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] got[$];
   logic [W-1:0] exp20[8] = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19};

   always #5 Clock = ~Clock;

   prime_search_ctrl #(.WIDTH(W), .COUNT_LIMIT(20)) u_l20 (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
      .Prime_Valid(v20), .Prime_Ready(Ready), .Prime_Data(d20), .Prime_Count(c20),
      .Busy(b20), .Done(dn20)
   );
   prime_search_ctrl #(.WIDTH(W), .COUNT_LIMIT(3)) u_l3 (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
      .Prime_Valid(v3), .Prime_Ready(Ready), .Prime_Data(d3), .Prime_Count(c3),
      .Busy(b3), .Done(dn3)
   );
   prime_search_ctrl #(.WIDTH(W), .COUNT_LIMIT(2)) u_l2 (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
      .Prime_Valid(v2), .Prime_Ready(Ready), .Prime_Data(d2), .Prime_Count(c2),
      .Busy(b2), .Done(dn2)
   );
   prime_search_ctrl #(.WIDTH(W), .COUNT_LIMIT(50)) u_l50 (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
      .Prime_Valid(v50), .Prime_Ready(Ready), .Prime_Data(d50), .Prime_Count(c50),
      .Busy(b50), .Done(dn50)
   );

   task automatic apply_reset();
      Reset_n = 1'b0;
      Start   = 1'b0;
      Abort   = 1'b0;
      Ready   = 1'b1;
      repeat (2) @(posedge Clock);
      #1 Reset_n = 1'b1;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0;
   endtask

   // Records every accepted prime of the limit-20 instance until Done; optional Start re-pulse.
   task automatic collect_l20(input int budget, input int restart_at);
      int i;
      got.delete();
      i = 0;
      while (!dn20 && i < budget) begin
         Start = (i == restart_at);
         if (v20 && Ready) got.push_back(d20);
         @(posedge Clock);
         #1;
         i++;
      end
      Start = 1'b0;
      checks++;
      if (dn20 !== 1'b1) begin
         errors++;
         $display("FAIL collect_timeout: done=%0b after %0d cycles, expected 1", dn20, budget);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({v20, b20, dn20, d20, c20} !== '0) begin
         errors++;
         $display("FAIL reset_l20: valid=%0b busy=%0b done=%0b data=%0d count=%0d, expected all 0",
                  v20, b20, dn20, d20, c20);
      end
      checks++;
      if ({v50, b50, dn50, d50, c50, dn2, b2} !== '0) begin
         errors++;
         $display("FAIL reset_others: l50 v=%0b b=%0b d=%0b l2 done=%0b busy=%0b, expected 0",
                  v50, b50, dn50, dn2, b2);
      end
   endtask

   task automatic test_stream(input string tag);
      collect_l20(4000, -1);
      checks++;
      if (got.size() != 8) begin
         errors++;
         $display("FAIL %s_len: got %0d primes, expected 8", tag, got.size());
      end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         checks++;
         if (got[i] !== exp20[i]) begin
            errors++;
            $display("FAIL %s_prime%0d: got %0d, expected %0d", tag, i, got[i], exp20[i]);
         end
      end
      checks++;
      if (c20 !== 16'd8 || b20 !== 1'b0 || dn20 !== 1'b1) begin
         errors++;
         $display("FAIL %s_final: count=%0d busy=%0b done=%0b, expected 8 0 1", tag, c20, b20, dn20);
      end
   endtask

   task automatic test_basic_stream();
      apply_reset();
      pulse_start();
      test_stream("basic");
   endtask

   task automatic test_back_to_back();
      // Restart straight from DONE without reset.
      pulse_start();
      checks++;
      if (dn20 !== 1'b0 || c20 !== 16'd0 || b20 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_restart: done=%0b count=%0d busy=%0b, expected 0 0 1", dn20, c20, b20);
      end
      test_stream("b2b");
   endtask

   task automatic test_backpressure();
      int n;
      apply_reset();
      Ready = 1'b0;
      pulse_start();
      n = 0;
      while (!v20 && n < 20) begin
         @(posedge Clock);
         #1;
         n++;
      end
      checks++;
      if (v20 !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid_timeout: valid=%0b, expected 1", v20);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (v20 !== 1'b1 || d20 !== 16'd2 || c20 !== 16'd0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%0b data=%0d count=%0d, expected 1 2 0",
                     i, v20, d20, c20);
         end
         @(posedge Clock);
         #1;
      end
      Ready = 1'b1;
      test_stream("bp");
   endtask

   task automatic test_small_limits();
      int n;
      apply_reset();
      Start = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0;
      checks++;
      if (dn2 !== 1'b1 || v2 !== 1'b0 || c2 !== 16'd0 || b2 !== 1'b0 || d2 !== 16'd0) begin
         errors++;
         $display("FAIL limit2: done=%0b valid=%0b count=%0d busy=%0b, expected 1 0 0 0",
                  dn2, v2, c2, b2);
      end
      got.delete();
      n = 0;
      while (!dn3 && n < 500) begin
         if (v3 && Ready) got.push_back(d3);
         @(posedge Clock);
         #1;
         n++;
      end
      checks++;
      if (got.size() != 1 || c3 !== 16'd1 || dn3 !== 1'b1 || b3 !== 1'b0) begin
         errors++;
         $display("FAIL limit3: primes=%0d count=%0d done=%0b busy=%0b, expected 1 1 1 0",
                  got.size(), c3, dn3, b3);
      end else begin
         checks++;
         if (got[0] !== 16'd2) begin
            errors++;
            $display("FAIL limit3_value: got %0d, expected 2", got[0]);
         end
      end
   endtask

   task automatic test_abort();
      int n;
      apply_reset();
      pulse_start();
      n = 0;
      while (c50 != 16'd4 && n < 2000) begin
         @(posedge Clock);
         #1;
         n++;
      end
      checks++;
      if (c50 !== 16'd4) begin
         errors++;
         $display("FAIL abort_reach4: count=%0d, expected 4", c50);
      end
      repeat (AbortDelay) begin
         @(posedge Clock);
         #1;
      end
      checks++;
      if (b50 !== 1'b1 || c50 !== 16'd4) begin
         errors++;
         $display("FAIL abort_pre: busy=%0b count=%0d, expected 1 4", b50, c50);
      end
      Abort = 1'b1;
      @(posedge Clock);
      #1 Abort = 1'b0;
      checks++;
      if (v50 !== 1'b0 || b50 !== 1'b0 || dn50 !== 1'b0 || c50 !== 16'd4) begin
         errors++;
         $display("FAIL abort_post: valid=%0b busy=%0b done=%0b count=%0d, expected 0 0 0 4",
                  v50, b50, dn50, c50);
      end
      pulse_start();
      checks++;
      if (b50 !== 1'b1 || c50 !== 16'd0) begin
         errors++;
         $display("FAIL abort_restart: busy=%0b count=%0d, expected 1 0", b50, c50);
      end
      n = 0;
      while (!v50 && n < 50) begin
         @(posedge Clock);
         #1;
         n++;
      end
      checks++;
      if (v50 !== 1'b1 || d50 !== 16'd2) begin
         errors++;
         $display("FAIL abort_first_prime: valid=%0b data=%0d, expected 1 2", v50, d50);
      end
   endtask

   task automatic test_start_abort_priority();
      apply_reset();
      pulse_start();
      test_stream("busy_start");
      apply_reset();
      pulse_start();
      collect_l20(4000, 5);
      checks++;
      if (got.size() != 8 || c20 !== 16'd8) begin
         errors++;
         $display("FAIL busy_start_ignored: primes=%0d count=%0d, expected 8 8", got.size(), c20);
      end
      pulse_start();
      repeat (4) @(posedge Clock);
      #1 Start = 1'b1;
      Abort = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0;
      Abort = 1'b0;
      checks++;
      if (b20 !== 1'b0 || dn20 !== 1'b0 || v20 !== 1'b0) begin
         errors++;
         $display("FAIL start_abort_busy: busy=%0b done=%0b valid=%0b, expected 0 0 0",
                  b20, dn20, v20);
      end
      Start = 1'b1;
      Abort = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0;
      Abort = 1'b0;
      checks++;
      if (b20 !== 1'b0 || dn20 !== 1'b0) begin
         errors++;
         $display("FAIL start_abort_idle: busy=%0b done=%0b, expected 0 0", b20, dn20);
      end
   endtask

   task automatic test_async_reset();
      int n;
      apply_reset();
      pulse_start();
      n = 0;
      while (c20 < 16'd2 && n < 500) begin
         @(posedge Clock);
         #1;
         n++;
      end
      repeat (6) @(posedge Clock);
      #3 Reset_n = 1'b0;
      #1;
      checks++;
      if ({v20, b20, dn20, d20, c20} !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%0b busy=%0b done=%0b data=%0d count=%0d, expected 0",
                  v20, b20, dn20, d20, c20);
      end
      @(posedge Clock);
      #1 Reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_stream();
      test_back_to_back();
      test_backpressure();
      test_small_limits();
      test_abort();
      test_start_abort_priority();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
